// File: rtl/clk_div_prog.sv
// clk_div_prog: NCH independent programmable clock dividers, 50% duty for odd and even divisors.
// Odd divisors stretch the posedge phase by half a cycle through a negedge copy ORed onto the output.
module clk_div_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t           r_state, w_state_nx;
  logic             r_arm, r_ph, r_nph, r_pv, w_ph_nx, w_pv_nx, w_legal, w_wrap;
  logic [WIDTH-1:0] r_cnt, r_a, r_pend, w_cnt_nx, w_a_nx, w_pend_nx;
  assign w_legal = load && (div_val > WIDTH'(1));
  assign w_wrap  = r_cnt == r_a - WIDTH'(1);
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_a_nx     = r_a;
    w_pend_nx  = r_pend;
    w_pv_nx    = r_pv;
    w_ph_nx    = r_ph;
    if (r_arm) begin
      if (r_state == IDLE) begin
        w_a_nx     = w_legal ? div_val : r_a;
        w_state_nx = en ? RUN : IDLE;
        w_ph_nx    = en;
      end else begin
        w_cnt_nx   = w_wrap ? '0 : r_cnt + WIDTH'(1);
        w_pend_nx  = w_legal ? div_val : r_pend;
        w_pv_nx    = !w_wrap && (r_pv || w_legal);
        w_a_nx     = !w_wrap ? r_a : w_legal ? div_val : r_pv ? r_pend : r_a;
        w_state_nx = en ? RUN : w_wrap ? IDLE : STOP;
        w_ph_nx    = (en || !w_wrap) && (w_cnt_nx < (r_a >> 1));
      end
    end
  end
  // r_arm delays the first active edge by one clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm   <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= WIDTH'(2);
      r_pend  <= WIDTH'(2);
      r_pv    <= 1'b0;
      r_ph    <= 1'b0;
    end else begin
      r_arm   <= 1'b1;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_a     <= w_a_nx;
      r_pend  <= w_pend_nx;
      r_pv    <= w_pv_nx;
      r_ph    <= w_ph_nx;
    end
  end
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) r_nph <= 1'b0;
    else        r_nph <= r_ph;
  end
  assign clk_out = r_a[0] ? (r_ph | r_nph) : r_ph;
  assign tick    = (r_state == RUN) && (r_cnt == '0);
endmodule

module clk_div_prog #(
  parameter int NCH   = 2,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] div_val,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    clk_div_chan #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[c]),
      .load    (load[c]),
      .div_val (div_val[c*WIDTH +: WIDTH]),
      .clk_out (clk_out[c]),
      .tick    (tick[c])
    );
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and random stimulus against a half-cycle reference model of each divider.
// A period of N cycles is 2N half-cycles; the output is high for the first N of them.
module tb_clk_div_prog;
  localparam int NCH = 2;
  localparam int W   = 8;
  logic           clk, rst_n;
  logic [NCH-1:0] en, load, clk_out, tick;
  logic [NCH*W-1:0] div_val;
  int n_chk, n_fail;
  int m_a[NCH], m_pos[NCH], m_pend[NCH];
  bit m_act[NCH];
  bit m_arm;

  clk_div_prog #(.NCH(NCH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .div_val(div_val), .clk_out(clk_out), .tick(tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic mreset();
    m_arm = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_a[c] = 2; m_pos[c] = 0; m_pend[c] = -1; m_act[c] = 1'b0;
    end
  endtask

  task automatic mstep(int c);
    int v;
    bit lg;
    v  = int'(div_val[c*W +: W]);
    lg = load[c] && v >= 2;
    if (!m_act[c]) begin
      if (lg) m_a[c] = v;
      if (en[c]) begin m_act[c] = 1'b1; m_pos[c] = 0; end
    end else begin
      if (lg) m_pend[c] = v;
      if (m_pos[c] == m_a[c] - 1) begin
        if (m_pend[c] >= 2) m_a[c] = m_pend[c];
        m_pend[c] = -1;
        m_pos[c]  = 0;
        m_act[c]  = en[c];
      end else m_pos[c]++;
    end
  endtask

  task automatic check(int half);
    for (int c = 0; c < NCH; c++) begin
      logic eo, et;
      eo = m_act[c] && (2 * m_pos[c] + half < m_a[c]);
      et = m_act[c] && (m_pos[c] == 0);
      n_chk++;
      assert (clk_out[c] === eo) else begin
        n_fail++;
        $error("FAIL clk_out ch%0d half%0d t=%0t: got %b expected %b", c, half, $time, clk_out[c], eo);
      end
      n_chk++;
      assert (tick[c] === et) else begin
        n_fail++;
        $error("FAIL tick ch%0d half%0d t=%0t: got %b expected %b", c, half, $time, tick[c], et);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    if (!rst_n) mreset();
    else if (!m_arm) m_arm = 1'b1;
    else for (int c = 0; c < NCH; c++) mstep(c);
    check(0);
    @(negedge clk); #1;
    check(1);
  endtask

  task automatic ld(int c, int v);
    load[c] = 1'b1;
    div_val[c*W +: W] = W'(v);
    cyc();
    load[c] = 1'b0;
  endtask

  task automatic run_until(int c, int a, int p);
    int k;
    k = 0;
    while (!(m_act[c] && m_a[c] == a && m_pos[c] == p) && k < 600) begin
      cyc();
      k++;
    end
    n_chk++;
    assert (k < 600) else begin
      n_fail++;
      $error("FAIL wait ch%0d: got no N=%0d cnt=%0d within %0d cycles, expected it", c, a, p, k);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    mreset();
    rst_n = 1'b1; en = '0; load = '0; div_val = '0;
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    ld(0, 4); ld(1, 5);
    en = '1;
    repeat (22) cyc();
    ld(0, 6);
    run_until(0, 6, 1);
    ld(0, 3);
    repeat (12) cyc();
    run_until(0, 3, 2);
    ld(0, 5);
    repeat (12) cyc();
    ld(0, 8);
    run_until(0, 8, 2);
    en[0] = 1'b0;
    repeat (16) cyc();
    ld(0, 0); ld(0, 1);
    en[0] = 1'b1;
    repeat (18) cyc();
    ld(1, 1); ld(1, 0);
    repeat (12) cyc();
    ld(0, 3); ld(0, 6);
    repeat (20) cyc();
    run_until(0, 6, 1);
    en[0] = 1'b0;
    cyc(); cyc();
    en[0] = 1'b1;
    repeat (14) cyc();
    run_until(0, 6, 2);
    en[0] = 1'b0;
    ld(0, 7);
    repeat (14) cyc();
    en[0] = 1'b1;
    ld(1, 255);
    repeat (270) cyc();
    ld(1, 2);
    run_until(1, 2, 0);
    run_until(0, 7, 1);
    rst_n = 1'b0;
    #1;
    n_chk++;
    assert (clk_out === '0) else begin
      n_fail++;
      $error("FAIL async_rst clk_out: got %b expected 00", clk_out);
    end
    n_chk++;
    assert (tick === '0) else begin
      n_fail++;
      $error("FAIL async_rst tick: got %b expected 00", tick);
    end
    mreset();
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (12) cyc();
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        en[c]   = $urandom_range(0, 7) != 0;
        load[c] = $urandom_range(0, 5) == 0;
        div_val[c*W +: W] = W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9));
      end
      cyc();
    end
    en = '0; load = '0;
    repeat (300) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter NCH, default 2, number of independent divider channels (1..8).
REQ-002 Parameter WIDTH, default 8, bit width of each channel's divisor (2..16).
REQ-003 clk  input  1  single system clock; all state is clocked by it, on both edges where stated below.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion takes effect at the next clk edge.
REQ-005 en  input  NCH  per-channel run request, level-sensitive, sampled on posedge clk.
REQ-006 load  input  NCH  per-channel one-cycle strobe; captures that channel's div_val slice on posedge clk.
REQ-007 div_val  input  NCH*WIDTH  divisor N per channel; channel i uses bits [i*WIDTH +: WIDTH].
REQ-008 clk_out  output  NCH  divided clock per channel, 50% duty for all legal N.
REQ-009 tick  output  NCH  one-clk-cycle pulse per channel marking the first cycle of each output period.

Function
REQ-010 Each channel SHALL be fully independent; the channels SHALL share only clk and rst_n.
REQ-011 Legal divisor range SHALL be 2..2^WIDTH-1. A load with N<2 SHALL be ignored, leaving the active and pending divisors unchanged.
REQ-012 Each channel SHALL hold an active divisor A, a pending divisor P, and a pending-valid flag PV.
REQ-013 Each channel SHALL have a WIDTH-bit posedge counter cnt running 0..A-1, then wrapping to 0.
REQ-014 The high count H SHALL be A>>1.
REQ-015 The posedge phase register p_r SHALL be registered high when the next value of cnt is less than H, and low otherwise.
REQ-016 For even A, clk_out SHALL equal p_r, giving H cycles high and H cycles low.
REQ-017 For odd A, a negedge register n_r SHALL capture p_r, and clk_out SHALL be p_r OR n_r, giving H+0.5 cycles high and H+0.5 cycles low.
REQ-018 clk_out SHALL be glitch-free: no runt pulse on enable, disable, or divisor change.
REQ-019 Each channel SHALL implement an FSM with states IDLE, RUN, STOP.
REQ-020 IDLE: cnt=0, p_r=0, n_r=0, tick=0. en=1 moves the channel to RUN.
REQ-021 On the first RUN posedge, cnt SHALL be 0, and p_r and tick SHALL be 1 (latency: clk_out rises one posedge after en is sampled high).
REQ-022 RUN with en=0 SHALL move to STOP. The current period SHALL complete, and at the wrap the channel SHALL enter IDLE with clk_out low.
REQ-023 STOP with en=1 SHALL return to RUN with no interruption or phase change.
REQ-024 tick SHALL be 1 for exactly the posedge cycle in which cnt=0 in RUN, and 0 otherwise.
REQ-025 A legal load in IDLE SHALL write A directly, effective on the next RUN entry.
REQ-026 A legal load in RUN or STOP SHALL write P and set PV. At the next wrap, A SHALL take P and PV SHALL clear.
REQ-027 When a legal load coincides with a wrap, the newly loaded value SHALL be applied at that wrap.
REQ-028 Successive loads within one period SHALL overwrite P, so the last one wins.
REQ-029 When a load coincides with en falling, the load SHALL be applied per REQ-026, and the channel SHALL still stop at the wrap.

Reset
REQ-030 While rst_n=0, every channel SHALL have: state=IDLE, cnt=0, p_r=0, n_r=0, clk_out=0, tick=0, A=2, P=2, PV=0.
REQ-031 Reset asserted mid-period SHALL force clk_out low immediately (asynchronous), with no completion of the current period.
REQ-032 After rst_n deasserts with en=1, output SHALL begin per REQ-021 on the second posedge.

Verification
REQ-033 Even divide: load N=4, en=1 -> clk_out 2 high/2 low, period 4; tick once every 4 cycles aligned to the rising edge.
REQ-034 Odd divide: load N=5 -> clk_out high 2.5 cycles, low 2.5 cycles (check negedge timing); period 5 cycles.
REQ-035 On-the-fly change: running N=6, load N=3 at cnt=1 -> the current 6-cycle period completes, then 3-cycle periods with no runt pulse.
REQ-036 Disable mid-period: N=8, en falls at cnt=2 -> high phase completes at cnt=3, low until cnt=7, then IDLE; no further ticks.
REQ-037 Illegal and boundary loads: load N=0 and N=1 ignored; load N=2^WIDTH-1 -> correct period; load coincident with wrap -> new N applied immediately.
REQ-038 Async reset: rst_n pulsed low at mid-high phase of N=7 on channel 0 while channel 1 runs N=2 -> both outputs low immediately; A reset to 2 on both.
